// File: rtl/control_sequencer.sv
// control_sequencer: T-state ring plus microcode decode for the 8-bit CPU.
// Owns the one-hot T1..T6 ring and the halted flag, and decodes the opcode
// and flags into the per-cycle control word that drives the datapath.
module control_sequencer #(
    parameter int INST_W   = 8,
    parameter int T_STATES = 6,
    parameter int CTRL_W   = 24
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                enable,
    input  logic [INST_W-1:0]   inst,
    input  logic                zero_flag,
    output logic [T_STATES-1:0] t_state,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                halted
);

    // Ring positions (one-hot, bit0 = T1)
    localparam logic [T_STATES-1:0] T1     = {{(T_STATES-1){1'b0}}, 1'b1};
    localparam logic [T_STATES-1:0] T2     = T1 << 1;
    localparam logic [T_STATES-1:0] T3     = T1 << 2;
    localparam logic [T_STATES-1:0] T4     = T1 << 3;
    localparam logic [T_STATES-1:0] T5     = T1 << 4;
    localparam logic [T_STATES-1:0] T6     = T1 << 5;
    localparam logic [T_STATES-1:0] T_LAST = T1 << (T_STATES-1);

    // Opcodes
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_STA  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_MOVB = 4'h8;
    localparam logic [3:0] OP_MOVC = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_LDX  = 4'hB;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Control word bit positions
    localparam int HLT_CLK   = 0;
    localparam int COUNT_PC  = 1;
    localparam int CLEAR_PC  = 2;
    localparam int EN_PC     = 3;
    localparam int LD_PC     = 4;
    localparam int LD_MAR    = 5;
    localparam int CE_RAM    = 6;
    localparam int WE_RAM    = 7;
    localparam int LD_IR     = 8;
    localparam int EN_IR     = 9;
    localparam int CLEAR_IR  = 10;
    localparam int LD_ACC    = 11;
    localparam int EN_ACC    = 12;
    localparam int SUB_MODE  = 13;
    localparam int EN_ALU    = 14;
    localparam int LD_B      = 15;
    localparam int LD_C      = 17;
    localparam int LD_OUT    = 22;
    localparam int EXT_FETCH = 23;

    logic [T_STATES-1:0] t_state_q, t_state_d;
    logic                halted_q, halted_d;
    logic [T_STATES-1:0] last_t;
    logic                legal;
    logic                last_step;
    logic                halt_now;
    logic [3:0]          opcode;

    assign opcode    = inst[INST_W-1 -: 4];
    assign legal     = (t_state_q != '0) && ((t_state_q & (t_state_q - T1)) == '0);
    assign last_step = (t_state_q == last_t) || (t_state_q == T_LAST);
    assign halt_now  = (t_state_q == T4) && (opcode == OP_HLT);

    // Final T-state of each opcode; the ring wraps to T1 on the edge after it
    always_comb begin
        last_t = T3;
        case (opcode)
            OP_LDA, OP_STA, OP_LDX:                    last_t = T5;
            OP_ADD, OP_SUB:                            last_t = T6;
            OP_LDI, OP_JMP, OP_OUT, OP_MOVB, OP_MOVC,
            OP_JZ, OP_HLT:                             last_t = T4;
            default:                                   last_t = T3;
        endcase
    end

    // Ring advance: clear dominates, halt freezes at T4, enable gates stepping
    always_comb begin
        t_state_d = t_state_q;
        halted_d  = halted_q;
        if (clear) begin
            t_state_d = T1;
            halted_d  = 1'b0;
        end else if (!halted_q && enable) begin
            if (!legal)
                t_state_d = T1;
            else if (halt_now)
                halted_d = 1'b1;
            else if (last_step)
                t_state_d = T1;
            else
                t_state_d = t_state_q << 1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (clear) begin
            t_state_q <= T1;
            halted_q  <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            halted_q  <= halted_d;
        end
    end

    // Control word decode; a frozen ring issues nothing so strobes never repeat
    always_comb begin
        ctrl = '0;
        if (clear) begin
            ctrl[CLEAR_PC] = 1'b1;
            ctrl[CLEAR_IR] = 1'b1;
        end else if (halted_q) begin
            ctrl[HLT_CLK] = 1'b1;
        end else if (enable && legal) begin
            case (t_state_q)
                T1: begin ctrl[EN_PC] = 1'b1; ctrl[LD_MAR] = 1'b1; end
                T2: ctrl[COUNT_PC] = 1'b1;
                T3: begin ctrl[CE_RAM] = 1'b1; ctrl[LD_IR] = 1'b1; end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ctrl[EN_IR] = 1'b1; ctrl[LD_MAR] = 1'b1; end
                        OP_LDI:  begin ctrl[EN_IR] = 1'b1;  ctrl[LD_ACC] = 1'b1; end
                        OP_JMP:  begin ctrl[EN_IR] = 1'b1;  ctrl[LD_PC] = 1'b1; end
                        OP_OUT:  begin ctrl[EN_ACC] = 1'b1; ctrl[LD_OUT] = 1'b1; end
                        OP_MOVB: begin ctrl[EN_ACC] = 1'b1; ctrl[LD_B] = 1'b1; end
                        OP_MOVC: begin ctrl[EN_ACC] = 1'b1; ctrl[LD_C] = 1'b1; end
                        OP_JZ: begin
                            ctrl[EN_IR] = zero_flag;
                            ctrl[LD_PC] = zero_flag;
                        end
                        OP_LDX: begin
                            ctrl[EN_PC]     = 1'b1;
                            ctrl[LD_MAR]    = 1'b1;
                            ctrl[EXT_FETCH] = 1'b1;
                        end
                        OP_HLT:  ctrl[HLT_CLK] = 1'b1;
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin ctrl[CE_RAM] = 1'b1; ctrl[LD_ACC] = 1'b1; end
                        OP_ADD, OP_SUB: begin
                            ctrl[CE_RAM]   = 1'b1;
                            ctrl[LD_B]     = 1'b1;
                            ctrl[SUB_MODE] = (opcode == OP_SUB);
                        end
                        OP_STA: begin ctrl[EN_ACC] = 1'b1; ctrl[WE_RAM] = 1'b1; end
                        OP_LDX: begin
                            ctrl[CE_RAM]    = 1'b1;
                            ctrl[LD_ACC]    = 1'b1;
                            ctrl[COUNT_PC]  = 1'b1;
                            ctrl[EXT_FETCH] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ctrl[EN_ALU]   = 1'b1;
                        ctrl[LD_ACC]   = 1'b1;
                        ctrl[SUB_MODE] = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_state = t_state_q;
    assign halted  = halted_q;

endmodule
